led_scan_driver: RTL and testbench

- Downstream consumer of the 16-bit LED PIO output (out_port).
- Displays the PIO value as four hex digits on a time-multiplexed, common-anode 7-segment display with a decimal point.
- Provides a per-digit scan prescaler and anti-ghosting blanking.
- Latches the input once per frame, so a displayed frame never mixes old and new digits.

---
 rtl/led_disp_pkg.sv | 36 +++
 rtl/led_scan_driver_if.sv | 26 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/led_scan_driver.sv | 128 ++++++++++++
 tb/tb_led_scan_driver.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/led_disp_pkg.sv
// Shared definitions for the multiplexed 7-segment LED display path.
// Provides digit geometry, the hex font table, the digit-index type,
// the scan state encoding and the packed pin payload driven to the display.
package led_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;

  typedef logic [1:0] digit_idx_t;

  // One state per digit slot; the encoding equals the digit index.
  typedef enum logic [1:0] {
    SCAN_D0 = 2'd0,
    SCAN_D1 = 2'd1,
    SCAN_D2 = 2'd2,
    SCAN_D3 = 2'd3
  } scan_state_t;

  // Segment patterns gfedcba, active high, indexed by nibble value.
  localparam logic [SEG_W-1:0] SEG7_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Active-low pin bundle registered in the output stage.
  typedef struct packed {
    logic [SEG_W-1:0]      seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] dig_n;
  } disp_pins_t;

  localparam disp_pins_t PINS_OFF = '{seg_n: 7'h7F, dp_n: 1'b1, dig_n: 4'hF};

endpackage

// File: rtl/led_scan_driver_if.sv
// Display bus between the PIO value source and the LED scan driver.
//   master: drives value_in / dp_in / enable, observes the display pins.
//   slave : the scan driver; consumes the value, drives seg_n / dp_n / dig_n
//           and the frame_tick pulse.
interface led_scan_driver_if;
  import led_disp_pkg::*;

  logic [VALUE_W-1:0]    value_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  enable;
  logic [SEG_W-1:0]      seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] dig_n;
  logic                  frame_tick;

  modport master (
    output value_in, dp_in, enable,
    input  seg_n, dp_n, dig_n, frame_tick
  );

  modport slave (
    input  value_in, dp_in, enable,
    output seg_n, dp_n, dig_n, frame_tick
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to 7-segment (gfedcba, active high) decoder.
//   nibble : hex digit value
//   seg_c  : segment pattern from the shared font table
module hex_to_seg7
  import led_disp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = SEG7_FONT[nibble];

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows the 16-bit PIO value as hex with per-digit decimal points, a
// blanking window at the start of every digit slot against ghosting, and
// optional leading-zero suppression. The value is latched once per frame.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : value_in, dp_in, enable in; seg_n, dp_n, dig_n,
//                  frame_tick out (all outputs registered)
module led_scan_driver
  import led_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned LZ_BLANK     = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  led_scan_driver_if.slave  bus
);

  localparam int unsigned PC_W = $clog2(SCAN_DIV);
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYCLES);

  // Elaboration-time configuration check.
  if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20) || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_cfg
    $error("led_scan_driver: need 2 <= SCAN_DIV <= 2^20 and BLANK_CYCLES < SCAN_DIV");
  end

  logic [PC_W-1:0]       pc_q, pc_d;
  scan_state_t           scan_q, scan_d;
  logic [VALUE_W-1:0]    shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  disp_pins_t            pins_q, pins_d;
  logic                  frame_tick_q, frame_tick_d;

  digit_idx_t            di_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic [SEG_W-1:0]      font_c;
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic                  digit_blank_c;
  logic                  pc_wrap_c;
  logic                  frame_start_c;
  logic [NUM_DIGITS-1:0] dig_sel_c;

  assign di_c     = digit_idx_t'(scan_q);
  assign nibble_c = shadow_val_q[{di_c, 2'b00} +: NIBBLE_W];

  hex_to_seg7 u_dec (
    .nibble (nibble_c),
    .seg_c  (font_c)
  );

  // lead_zero_c[i]: every nibble from the top down to digit i is zero.
  // Digit 0 is never suppressed so a zero value still shows "0".
  assign lead_zero_c[3] = (shadow_val_q[15:12] == 4'h0);
  assign lead_zero_c[2] = lead_zero_c[3] && (shadow_val_q[11:8] == 4'h0);
  assign lead_zero_c[1] = lead_zero_c[2] && (shadow_val_q[7:4] == 4'h0);
  assign lead_zero_c[0] = 1'b0;

  assign digit_blank_c = (LZ_BLANK != 0) && lead_zero_c[di_c];
  assign dig_sel_c     = NUM_DIGITS'(1) << di_c;

  // Next-state: prescaler, digit scan, frame latch and output stage.
  always_comb begin
    pc_d          = pc_q;
    scan_d        = scan_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    pins_d        = PINS_OFF;
    frame_tick_d  = 1'b0;
    pc_wrap_c     = (pc_q == PC_LAST);
    frame_start_c = 1'b0;

    if (pc_wrap_c) begin
      pc_d = '0;
      case (scan_q)
        SCAN_D0: scan_d = SCAN_D1;
        SCAN_D1: scan_d = SCAN_D2;
        SCAN_D2: scan_d = SCAN_D3;
        SCAN_D3: scan_d = SCAN_D0;
        default: scan_d = SCAN_D0;
      endcase
      frame_start_c = (scan_q == SCAN_D3);
    end else begin
      pc_d = pc_q + PC_W'(1);
    end

    // Latch the whole value at the frame boundary so a frame is coherent.
    if (frame_start_c) begin
      shadow_val_d = bus.value_in;
      shadow_dp_d  = bus.dp_in;
      frame_tick_d = 1'b1;
    end

    // Drive the digit only outside the blanking window and when enabled;
    // a suppressed leading zero keeps its anode on but lights no segments.
    if (bus.enable && (pc_q >= PC_BLANK)) begin
      pins_d.dig_n = ~dig_sel_c;
      pins_d.seg_n = digit_blank_c ? 7'h7F : ~font_c;
      pins_d.dp_n  = ~shadow_dp_q[di_c];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= '0;
      scan_q       <= SCAN_D0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pins_q       <= PINS_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      scan_q       <= scan_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pins_q       <= pins_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg_n      = pins_q.seg_n;
  assign bus.dp_n       = pins_q.dp_n;
  assign bus.dig_n      = pins_q.dig_n;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver: three instances (8/2 plain, 8/2 with
// leading-zero blanking, 2/1 boundary). Expected pin states keyed by cycle
// number after reset release are queued up front; a negedge monitor pops and
// compares the entries due in each cycle.
module tb_led_scan_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_scan_driver_if if_a ();
  led_scan_driver_if if_b ();
  led_scan_driver_if if_c ();

  led_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  led_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  led_scan_driver #(.SCAN_DIV(2), .BLANK_CYCLES(1), .LZ_BLANK(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  // Cycle number n = active edges since the last reset release.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    int         inst;
    int         n;
    bit         is_tick;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;

  task automatic push_pin(input int inst, input int n, input logic [3:0] dig,
                          input logic [6:0] seg, input logic dp);
    exp_t e;
    e.inst = inst; e.n = n; e.is_tick = 1'b0;
    e.dig = dig; e.seg = seg; e.dp = dp; e.ft = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_tick(input int inst, input int n, input logic ft);
    exp_t e;
    e.inst = inst; e.n = n; e.is_tick = 1'b1;
    e.dig = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = ft;
    q.push_back(e);
  endtask

  // One digit slot; pat is the active-high pattern (0 for a suppressed digit).
  task automatic push_slot(input int inst, input int n0, input int s, input int b,
                           input int d, input logic [6:0] pat, input logic dp_req,
                           input int dark_lo, input int dark_hi);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << d;
    for (int c = 0; c < s; c++) begin
      n = n0 + d * s + c + 1;
      if (c < b || (n >= dark_lo && n <= dark_hi))
        push_pin(inst, n, 4'hF, 7'h7F, 1'b1);
      else
        push_pin(inst, n, ~oh, ~pat, ~dp_req);
    end
  endtask

  task automatic push_frame(input int inst, input int n0, input int s, input int b,
                            input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3,
                            input logic [3:0] dp, input int dark_lo, input int dark_hi);
    push_slot(inst, n0, s, b, 0, p0, dp[0], dark_lo, dark_hi);
    push_slot(inst, n0, s, b, 1, p1, dp[1], dark_lo, dark_hi);
    push_slot(inst, n0, s, b, 2, p2, dp[2], dark_lo, dark_hi);
    push_slot(inst, n0, s, b, 3, p3, dp[3], dark_lo, dark_hi);
  endtask

  task automatic chk_reset(input string nm, input logic [3:0] dig, input logic [6:0] seg,
                           input logic dp, input logic ft);
    n_cmp++;
    if ({dig, seg, dp, ft} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s async reset: dig_n=%b seg_n=%h dp_n=%b tick=%b, expected 1111 7f 1 0",
               nm, dig, seg, dp, ft);
    end
  endtask

  // Monitor: compare every expectation due in this cycle.
  logic [3:0] m_dig;
  logic [6:0] m_seg;
  logic       m_dp;
  logic       m_ft;
  always @(negedge clk) begin
    if (mon_on && reset_n) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].n == cyc) begin
          case (q[i].inst)
            0:       begin m_dig = if_a.dig_n; m_seg = if_a.seg_n; m_dp = if_a.dp_n; m_ft = if_a.frame_tick; end
            1:       begin m_dig = if_b.dig_n; m_seg = if_b.seg_n; m_dp = if_b.dp_n; m_ft = if_b.frame_tick; end
            default: begin m_dig = if_c.dig_n; m_seg = if_c.seg_n; m_dp = if_c.dp_n; m_ft = if_c.frame_tick; end
          endcase
          n_cmp++;
          if (q[i].is_tick) begin
            if (m_ft !== q[i].ft) begin
              n_bad++;
              $display("FAIL inst%0d n=%0d frame_tick: got %b, expected %b",
                       q[i].inst, cyc, m_ft, q[i].ft);
            end
          end else if ({m_dig, m_seg, m_dp} !== {q[i].dig, q[i].seg, q[i].dp}) begin
            n_bad++;
            $display("FAIL inst%0d n=%0d pins: got dig_n=%b seg_n=%h dp_n=%b, expected dig_n=%b seg_n=%h dp_n=%b",
                     q[i].inst, cyc, m_dig, m_seg, m_dp, q[i].dig, q[i].seg, q[i].dp);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.value_in = 16'h3136; if_a.dp_in = 4'b0000; if_a.enable = 1'b1;
    if_b.value_in = 16'h0050; if_b.dp_in = 4'b0000; if_b.enable = 1'b1;
    if_c.value_in = 16'hF0F0; if_c.dp_in = 4'b0000; if_c.enable = 1'b1;

    // First release, then assert reset in the middle of digit 1's slot.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (13) @(posedge clk);
    #2;
    n_cmp++;
    if (if_a.dig_n !== 4'b1101) begin
      n_bad++;
      $display("FAIL pre-reset dig_n: got %b, expected 1101", if_a.dig_n);
    end
    reset_n = 1'b0;
    #1;
    chk_reset("inst0", if_a.dig_n, if_a.seg_n, if_a.dp_n, if_a.frame_tick);
    chk_reset("inst1", if_b.dig_n, if_b.seg_n, if_b.dp_n, if_b.frame_tick);
    chk_reset("inst2", if_c.dig_n, if_c.seg_n, if_c.dp_n, if_c.frame_tick);

    @(negedge clk);
    reset_n = 1'b1;

    // inst0: plain scan, frame coherency, decimal point, enable gap 171..175.
    push_frame(0,   0, 8, 2, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, -1, -1);
    push_frame(0,  32, 8, 2, 7'h7D, 7'h4F, 7'h06, 7'h4F, 4'b0000, -1, -1);
    push_frame(0,  64, 8, 2, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, -1, -1);
    push_frame(0,  96, 8, 2, 7'h5E, 7'h39, 7'h7C, 7'h77, 4'b0000, -1, -1);
    push_frame(0, 128, 8, 2, 7'h5E, 7'h39, 7'h7C, 7'h77, 4'b0100, -1, -1);
    push_frame(0, 160, 8, 2, 7'h5E, 7'h39, 7'h7C, 7'h77, 4'b0100, 171, 175);
    for (int n = 1; n <= 195; n++) push_tick(0, n, (n % 32) == 0);

    // inst1: leading-zero blanking.
    push_frame(1,   0, 8, 2, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, -1, -1);
    push_frame(1,  32, 8, 2, 7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000, -1, -1);
    push_frame(1,  64, 8, 2, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, -1, -1);

    // inst2: minimum slot length.
    push_frame(2,  0, 2, 1, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, -1, -1);
    for (int f = 1; f <= 4; f++)
      push_frame(2, 8 * f, 2, 1, 7'h3F, 7'h71, 7'h3F, 7'h71, 4'b0000, -1, -1);
    for (int n = 1; n <= 40; n++) push_tick(2, n, (n % 8) == 0);

    mon_on = 1'b1;

    wait (cyc >= 40);  @(negedge clk); if_b.value_in = 16'h0000;
    wait (cyc >= 50);  @(negedge clk); if_a.value_in = 16'h1234;
    wait (cyc >= 85);  @(negedge clk); if_a.value_in = 16'hABCD;
    wait (cyc >= 100); @(negedge clk); if_a.dp_in = 4'b0100;
    wait (cyc >= 170); @(negedge clk); if_a.enable = 1'b0;
    wait (cyc >= 175); @(negedge clk); if_a.enable = 1'b1;
    wait (cyc >= 200); @(negedge clk); #1;

    // Anything still queued was never reached.
    foreach (q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL inst%0d n=%0d never checked: got nothing, expected a sample", q[i].inst, q[i].n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
